// File: rtl/pinwheel_console_tx.sv
// Pinwheel console TX: TileLink-A register slave with byte FIFO
// feeding an 8N1 serial transmitter with programmable bit period.
module pinwheel_console_tx #(
  parameter logic [3:0] BASE_TAG     = 4'h4,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic        clock,
  input  logic        tick_reset_in,
  input  logic [2:0]  tla_opcode,
  input  logic [31:0] tla_address,
  input  logic [3:0]  tla_mask,
  input  logic [31:0] tla_data,
  input  logic        tla_valid,
  output logic [2:0]  tld_opcode,
  output logic [31:0] tld_data,
  output logic        tld_valid,
  output logic        tx_out,
  output logic        tx_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [2:0] TL_GET = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic [15:0]     r_div_lat;
  logic [15:0]     r_clkcnt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [31:0]     r_total;
  logic            r_tx;
  logic            r_busy;
  logic            r_tld_valid;
  logic [2:0]      r_tld_opcode;
  logic [31:0]     r_tld_data;

  logic            w_is_get;
  logic            w_sel;
  logic            w_rd;
  logic            w_wr;
  logic [1:0]      w_idx;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_bit_end;
  logic            w_pop;
  logic            w_frame_done;
  logic [7:0]      w_cnt8;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_is_get = (tla_opcode == TL_GET);
  assign w_sel    = tla_valid
                 && (tla_address[31:28] == BASE_TAG)
                 && (w_is_get || (tla_mask != 4'd0));
  assign w_rd     = w_sel && w_is_get;
  assign w_wr     = w_sel && !w_is_get;
  assign w_idx    = tla_address[3:2];

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_wr && (w_idx == 2'd0) && !w_full;
  assign w_ovf_set = w_wr && (w_idx == 2'd0) && w_full;

  assign w_bit_end    = (r_clkcnt == r_div_lat - 16'd1);
  assign w_frame_done = (r_state == S_STOP) && w_bit_end;
  // Pop on idle, or chained straight out of a finished stop bit
  assign w_pop = !w_empty
              && ((r_state == S_IDLE) || w_frame_done);

  assign w_cnt8   = 8'(r_count);
  assign w_status = {16'd0, w_cnt8, 4'd0,
                     r_ovf, r_busy, w_empty, w_full};

  always_comb begin
    w_rdata = 32'd0;
    unique case (w_idx)
      2'd0: w_rdata = 32'd0;
      2'd1: w_rdata = w_status;
      2'd2: w_rdata = {16'd0, r_div};
      2'd3: w_rdata = r_total;
    endcase
  end

  assign w_unused = ^{tla_address[27:4], tla_address[1:0],
                      tla_data[31:16]};

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= tla_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_div        <= 16'(CLKS_PER_BIT);
      r_div_lat    <= 16'd1;
      r_clkcnt     <= 16'd0;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'd0;
      r_total      <= 32'd0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_tld_valid  <= 1'b0;
      r_tld_opcode <= 3'd0;
      r_tld_data   <= 32'd0;
    end else begin
      r_tld_valid  <= w_sel;
      r_tld_opcode <= w_rd ? 3'd1 : 3'd0;
      r_tld_data   <= w_rd ? w_rdata : 32'd0;

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_wr && (w_idx == 2'd1))   r_ovf <= 1'b0;
      else if (w_ovf_set)            r_ovf <= 1'b1;

      if (w_wr && (w_idx == 2'd2))   r_div <= tla_data[15:0];

      if (w_wr && (w_idx == 2'd3))   r_total <= 32'd0;
      else if (w_frame_done)         r_total <= r_total + 32'd1;

      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_div_lat <= (r_div == 16'd0) ? 16'd1 : r_div;
        r_clkcnt  <= 16'd0;
        r_bitcnt  <= 3'd0;
        r_state   <= S_START;
        r_tx      <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
          S_START, S_DATA: begin
            if (!w_bit_end) begin
              r_clkcnt <= r_clkcnt + 16'd1;
            end else if (r_state == S_DATA
                         && r_bitcnt == 3'd7) begin
              r_clkcnt <= 16'd0;
              r_state  <= S_STOP;
              r_tx     <= 1'b1;
            end else begin
              r_clkcnt <= 16'd0;
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              if (r_state == S_DATA)
                r_bitcnt <= r_bitcnt + 3'd1;
              r_state  <= S_DATA;
            end
          end
          S_STOP: begin
            if (!w_bit_end) begin
              r_clkcnt <= r_clkcnt + 16'd1;
            end else begin
              r_clkcnt <= 16'd0;
              r_state  <= S_IDLE;
              r_tx     <= 1'b1;
              r_busy   <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign tld_valid  = r_tld_valid;
  assign tld_opcode = r_tld_opcode;
  assign tld_data   = r_tld_data;
  assign tx_out     = r_tx;
  assign tx_busy    = r_busy;

endmodule

// File: tb/tb_pinwheel_console_tx.sv
// Bench for pinwheel_console_tx: bus response scoreboard plus
// a serial line monitor checking every bit cycle of each frame.
module tb_pinwheel_console_tx;

  localparam logic [2:0] GET  = 3'd4;
  localparam logic [2:0] PUTP = 3'd1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic        clock = 1'b0;
  logic        tick_reset_in;
  logic [2:0]  tla_opcode;
  logic [31:0] tla_address;
  logic [3:0]  tla_mask;
  logic [31:0] tla_data;
  logic        tla_valid;
  logic [2:0]  tld_opcode;
  logic [31:0] tld_data;
  logic        tld_valid;
  logic        tx_out;
  logic        tx_busy;

  rsp_t       sb_q[$];
  logic [7:0] tx_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit bus_en   = 1'b0;
  bit mon_en   = 1'b0;
  int mon_div  = 4;
  int busy_tot = 0;
  int busy_run = 0;
  int last_run = 0;
  int b0;

  always #5 clock = ~clock;

  pinwheel_console_tx dut (
    .clock        (clock),
    .tick_reset_in(tick_reset_in),
    .tla_opcode   (tla_opcode),
    .tla_address  (tla_address),
    .tla_mask     (tla_mask),
    .tla_data     (tla_data),
    .tla_valid    (tla_valid),
    .tld_opcode   (tld_opcode),
    .tld_data     (tld_data),
    .tld_valid    (tld_valid),
    .tx_out       (tx_out),
    .tx_busy      (tx_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status(input int cnt,
                                         input bit ovf,
                                         input bit busy);
    logic [7:0] c8;
    c8 = 8'(cnt);
    return {16'h0, c8, 4'h0, ovf, busy,
            cnt == 0, cnt == 16};
  endfunction

  task automatic idle();
    tla_opcode  = PUTP;
    tla_address = 32'd0;
    tla_mask    = 4'd0;
    tla_data    = 32'd0;
    tla_valid   = 1'b1;
  endtask

  task automatic req(input logic [2:0]  op,
                     input logic [31:0] addr,
                     input logic [3:0]  mask,
                     input logic [31:0] data,
                     input bit          sel,
                     input logic [31:0] exp);
    rsp_t e;
    tla_opcode  = op;
    tla_address = addr;
    tla_mask    = mask;
    tla_data    = data;
    tla_valid   = 1'b1;
    if (sel) begin
      e.op   = (op == GET) ? 3'd1 : 3'd0;
      e.data = exp;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp);
    req(GET, a, 4'd0, 32'd0, 1'b1, exp);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    req(PUTP, a, 4'hF, d, 1'b1, 32'd0);
  endtask

  task automatic chk_reset_out(input string t);
    check({t, "_tx"},   tx_out,     1);
    check({t, "_busy"}, tx_busy,    0);
    check({t, "_vld"},  tld_valid,  0);
    check({t, "_dat"},  tld_data,   0);
    check({t, "_op"},   tld_opcode, 0);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clock);
      if (bus_en) begin
        if (tld_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("rsp_spurious", tld_valid, 0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_op",  tld_opcode, e.op);
            check("rsp_dat", tld_data,   e.data);
            check("rsp_cyc", cyc,        e.cyc);
          end
        end else if (tld_valid !== 1'b0
                     || tld_data !== 32'd0
                     || tld_opcode !== 3'd0) begin
          check("rsp_idle", {tld_valid, tld_opcode,
                             tld_data[27:0]}, 0);
        end
      end
    end
  end

  initial begin : tx_mon
    logic       prev;
    logic [9:0] fr;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && prev === 1'b1 && tx_out === 1'b0) begin
        if (tx_q.size() == 0) begin
          check("tx_unexp", 1, 0);
        end else begin
          b  = tx_q.pop_front();
          fr = {1'b1, b, 1'b0};
          for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < mon_div; c++) begin
              if (k != 0 || c != 0) @(negedge clock);
              check("tx_bit", tx_out, fr[k]);
            end
          end
        end
      end
      prev = tx_out;
    end
  end

  initial begin : busy_mon
    forever begin
      @(negedge clock);
      if (tx_busy === 1'b1) begin
        busy_tot++;
        busy_run++;
      end else begin
        if (busy_run != 0) last_run = busy_run;
        busy_run = 0;
      end
    end
  end

  initial begin
    idle();
    tick_reset_in = 1'b1;
    tla_opcode    = GET;
    tla_address   = 32'h4000_0004;
    repeat (3) @(posedge clock);
    #1;
    tick_reset_in = 1'b0;
    idle();
    bus_en = 1'b1;
    chk_reset_out("rst");

    rd(32'h4000_0004, status(0, 0, 0));
    rd(32'h4000_0008, 32'd4);
    rd(32'h4000_000C, 32'd0);
    rd(32'h4000_0000, 32'd0);
    repeat (2) @(posedge clock);
    #1;

    // Single frame 0x41 at divisor 4, byte lane 2 mask
    mon_div = 4;
    mon_en  = 1'b1;
    tx_q.push_back(8'h41);
    b0 = busy_tot;
    req(PUTP, 32'h4000_0000, 4'b0100, 32'hDEAD_BE41,
        1'b1, 32'd0);
    check("tx_hold", tx_out, 1);
    @(posedge clock);
    #1;
    check("tx_fall", tx_out, 0);
    check("busy_rise", tx_busy, 1);
    repeat (45) @(posedge clock);
    #1;
    check("busy_len1", busy_tot - b0, 40);
    check("busy_run1", last_run, 40);
    check("txq1", tx_q.size(), 0);
    rd(32'h4000_000C, 32'd1);
    rd(32'h4000_0004, status(0, 0, 0));

    // Two chained frames at divisor 2
    wr(32'h4000_0008, 32'd2);
    rd(32'h4ABC_DE08, 32'd2);
    wr(32'h4000_000C, 32'h1234);
    rd(32'h4000_000C, 32'd0);
    mon_div = 2;
    tx_q.push_back(8'h55);
    tx_q.push_back(8'hAA);
    b0 = busy_tot;
    req(PUTP, 32'h4000_0000, 4'b0001, 32'h55, 1'b1, 32'd0);
    req(PUTP, 32'h4000_0000, 4'b1000, 32'hAA, 1'b1, 32'd0);
    repeat (45) @(posedge clock);
    #1;
    check("busy_len2", busy_tot - b0, 40);
    check("busy_run2", last_run, 40);
    check("txq2", tx_q.size(), 0);
    rd(32'h4000_000C, 32'd2);
    mon_en = 1'b0;

    // Overflow with the line stalled on a very slow frame
    wr(32'h4000_0008, 32'h0000_FFFF);
    for (int i = 0; i < 20; i++)
      req(PUTP, 32'h4000_0000, 4'b0001, 32'h30 + i,
          1'b1, 32'd0);
    rd(32'h4000_0004, status(16, 1, 1));
    wr(32'h4000_0004, 32'd0);
    rd(32'h4000_0004, status(16, 0, 1));
    req(PUTP, 32'h4000_0000, 4'b0001, 32'h7E, 1'b1, 32'd0);
    rd(32'h4000_0004, status(16, 1, 1));
    tick_reset_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tick_reset_in = 1'b0;
    chk_reset_out("rst2");
    rd(32'h4000_0004, status(0, 0, 0));
    rd(32'h4000_0008, 32'd4);
    rd(32'h4000_000C, 32'd0);

    // Requests that must not select this block
    req(PUTP, 32'h5000_0000, 4'b0001, 32'h77, 1'b0, 32'd0);
    check("oth_wr_vld", tld_valid, 0);
    req(GET, 32'h5000_0004, 4'b0000, 32'd0, 1'b0, 32'd0);
    check("oth_rd_vld", tld_valid, 0);
    req(PUTP, 32'h4000_0000, 4'b0000, 32'h66, 1'b0, 32'd0);
    check("mask0_vld", tld_valid, 0);
    repeat (3) @(posedge clock);
    #1;
    check("oth_busy", tx_busy, 0);
    rd(32'h4000_0004, status(0, 0, 0));

    // Reset during data bit 3 of 0xA5
    req(PUTP, 32'h4000_0000, 4'b0001, 32'hA5, 1'b1, 32'd0);
    repeat (16) @(posedge clock);
    #1;
    check("bit2", tx_out, 1);
    @(posedge clock);
    #1;
    check("bit3", tx_out, 0);
    check("bit3_busy", tx_busy, 1);
    tick_reset_in = 1'b1;
    @(posedge clock);
    #1;
    tick_reset_in = 1'b0;
    chk_reset_out("rst3");
    rd(32'h4000_0004, status(0, 0, 0));
    rd(32'h4000_0008, 32'd4);
    rd(32'h4000_000C, 32'd0);

    repeat (3) @(posedge clock);
    #1;
    check("sb_left", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
